// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory port bundle for mem_access_ctrl.
// slave = the controller, master = the MEM stage / memory side.
interface mem_access_ctrl_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_fault;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_byte_enable;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_resp;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the single data-memory port with load extension.
// Optional MISALIGN_SPLIT_EN: misaligned accesses split into two word accesses.
module mem_access_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC1  = 3'd1,
        ACC2  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_e;

    state_e           state_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_fault_q;
    logic [WIDTH-1:0] rdata_q;
    logic             rd_q;
    logic             wr_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       be_q;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             write_q;

    logic [1:0]       off;
    logic [1:0]       size;
    logic             illegal;
    logic             misal;
    logic             fault_req;
    logic             hs;
    logic [3:0]       mask;
    logic [WIDTH-1:0] wd_lo;
    logic [3:0]       be_lo;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] ext;

`ifdef MISALIGN_SPLIT_EN
    logic             split_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] wdata_hi_q;
    logic [3:0]       be_hi_q;
    logic [63:0]      wd64;
    logic [7:0]       be8;
    logic [63:0]      rd64;
    logic [WIDTH-1:0] wd_hi;
    logic [3:0]       be_hi;
`endif

    always_comb begin
        off     = bus.req_addr[1:0];
        size    = bus.req_funct3[1:0];
        illegal = (bus.req_funct3 == 3'b011)
                | (bus.req_funct3[2:1] == 2'b11)
                | (bus.req_write & bus.req_funct3[2]);
        misal   = ((size == 2'b01) && (off == 2'b11))
                | ((size == 2'b10) && (off != 2'b00));
        hs      = bus.req_valid & req_ready_q;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
`ifdef MISALIGN_SPLIT_EN
        fault_req = illegal;
        wd64  = {32'b0, bus.req_wdata} << {off, 3'b000};
        be8   = {4'b0, mask} << off;
        wd_lo = wd64[31:0];
        wd_hi = wd64[63:32];
        be_lo = be8[3:0];
        be_hi = be8[7:4];
`else
        fault_req = illegal | misal;
        wd_lo = bus.req_wdata << {off, 3'b000};
        be_lo = mask << off;
`endif
    end

    // Second beat of a split load concatenates above the latched first word.
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        rd64 = (split_q && (state_q == ACC2)) ? {bus.mem_rdata, lo_q}
                                               : {32'b0, bus.mem_rdata};
        sel  = 32'(rd64 >> {off_q, 3'b000});
`else
        sel  = bus.mem_rdata >> {off_q, 3'b000};
`endif
        case (size_q)
            2'b00:   ext = uns_q ? {24'b0, sel[7:0]}
                                 : {{24{sel[7]}}, sel[7:0]};
            2'b01:   ext = uns_q ? {16'b0, sel[15:0]}
                                 : {{16{sel[15]}}, sel[15:0]};
            default: ext = sel;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            rdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            lo_q         <= '0;
            wdata_hi_q   <= '0;
            be_hi_q      <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        req_ready_q <= 1'b0;
                        off_q       <= off;
                        size_q      <= size;
                        uns_q       <= bus.req_funct3[2];
                        write_q     <= bus.req_write;
                        if (fault_req) begin
                            state_q      <= FAULT;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            rdata_q      <= '0;
                        end else begin
                            state_q <= ACC1;
                            addr_q  <= {bus.req_addr[WIDTH-1:2], 2'b00};
                            wdata_q <= bus.req_write ? wd_lo : '0;
                            be_q    <= bus.req_write ? be_lo : 4'b0;
                            rd_q    <= ~bus.req_write;
                            wr_q    <= bus.req_write;
`ifdef MISALIGN_SPLIT_EN
                            split_q    <= misal;
                            wdata_hi_q <= bus.req_write ? wd_hi : '0;
                            be_hi_q    <= bus.req_write ? be_hi : 4'b0;
`endif
                        end
                    end
                end
                ACC1: begin
                    if (bus.mem_resp) begin
                        rd_q <= 1'b0;
                        wr_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
                        if (split_q) begin
                            state_q <= ACC2;
                            lo_q    <= bus.mem_rdata;
                        end else begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= write_q ? '0 : ext;
                        end
`else
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= write_q ? '0 : ext;
`endif
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                // First ACC2 cycle is the strobe-low gap; the high word issues next.
                ACC2: begin
                    if (!(rd_q | wr_q)) begin
                        addr_q  <= addr_q + 32'd4;
                        wdata_q <= wdata_hi_q;
                        be_q    <= be_hi_q;
                        rd_q    <= ~write_q;
                        wr_q    <= write_q;
                    end else if (bus.mem_resp) begin
                        rd_q         <= 1'b0;
                        wr_q         <= 1'b0;
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= write_q ? '0 : ext;
                    end
                end
`endif
                DONE, FAULT: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rdata_q     <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rd_q        <= 1'b0;
                    wr_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_fault      = resp_fault_q;
    assign bus.resp_rdata      = rdata_q;
    assign bus.mem_read        = rd_q;
    assign bus.mem_write       = wr_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;
endmodule
